// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, error codes,
// default geometry and the address legality check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_LATENCY     = 2;

  // Misalignment takes priority; the range check uses the full word address.
  function automatic logic [1:0] err_code(input logic [31:0] addr, input int depth_words);
    logic [1:0] code;
    code = ERR_NONE;
    if (addr[1:0] != 2'b00) begin
      code = ERR_MISALIGN;
    end else if ({2'b00, addr[31:2]} >= 32'(depth_words)) begin
      code = ERR_RANGE;
    end
    return code;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port 32-bit word array with per-byte write enables and a registered read.
// Storage is never reset; only the read-data register is.
module dmem_responder_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic                           i_clr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [3:0]                     i_be,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Any non-write access updates the read register; i_clr forces zero for errored accesses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= i_clr ? '0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, fixed access latency,
// one-cycle ack strobe, combinational stall while an access is outstanding.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_err;
  logic [31:0] w_rdata;

  assign w_accept     = (r_state == ST_IDLE) && req_i;
  assign w_enter_resp = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_err        = (err_code(r_addr, DEPTH_WORDS) != ERR_NONE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // WAIT lasts LATENCY cycles so the ack lands in the cycle after edge accept+LATENCY.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_i) w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_o   = (r_state == ST_RESP);
    err_o   = (r_state == ST_RESP) && w_err;
    stall_o = w_accept || (r_state == ST_WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= 4'(LATENCY - 1);
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_be    <= be_i;
      r_wdata <= wdata_i;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Errored stores fall onto the read path with clear asserted, so rdata_o reads zero.
  dmem_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_en    (w_enter_resp),
    .i_we    (r_we && !w_err),
    .i_clr   (w_err),
    .i_addr  (r_addr[AW+1:2]),
    .i_be    (r_be),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign rdata_o = w_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level memory model predicts each
// response at request time; responses are popped and compared on ack.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req, we, ack, err, stall;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        req3, we3, ack3, err3, stall3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  int tests = 0;
  int fails = 0;

  exp_t        exp_q[$];
  logic [31:0] mdl [0:1023];
  logic [31:0] last_rd;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .err_o(err), .stall_o(stall)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req3), .we_i(we3), .addr_i(addr3), .be_i(be3),
    .wdata_i(wdata3), .ack_o(ack3), .rdata_o(rdata3), .err_o(err3), .stall_o(stall3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_push(input logic w, input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d);
    exp_t       e;
    logic [9:0] idx;
    idx   = a[11:2];
    e.err = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
    if (e.err) begin
      last_rd = '0;
    end else if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
    end else begin
      last_rd = mdl[idx];
    end
    e.rdata = last_rd;
    exp_q.push_back(e);
  endtask

  // Drives one request, scrambles inputs after acceptance, waits (bounded) for ack.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int n, output logic [31:0] o_rd,
                        output logic o_err, output logic o_stall, output exp_t e);
    model_push(w, a, b, d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = $urandom; be = 4'hF; wdata = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 20);
    o_rd = rdata; o_err = err; o_stall = stall;
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 0; we = 0; addr = 0; be = 0; wdata = 0;
    req3 = 0; we3 = 0; addr3 = 0; be3 = 0; wdata3 = 0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ack, err, stall, rdata} !== 35'd0) begin
      fails++;
      $display("FAIL reset_outputs: ack/err/stall/rdata got %b/%b/%b/%h required 0/0/0/00000000",
               ack, err, stall, rdata);
    end
    tests++;
    if ({ack3, err3, stall3} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs_lat3: ack/err/stall got %b/%b/%b required 0/0/0", ack3, err3, stall3);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int n; logic [31:0] rd; logic er, st; exp_t e;
    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, n, rd, er, st, e);
    tests++;
    if (n !== 3 || st !== 1'b0) begin
      fails++;
      $display("FAIL store_latency: ack at cycle %0d stall %b, required cycle 3 stall 0", n, st);
    end
    tests++;
    if (er !== e.err) begin
      fails++;
      $display("FAIL store_err: got %b required %b", er, e.err);
    end
    access(1'b0, 32'h10, 4'h0, 32'h0, n, rd, er, st, e);
    tests++;
    if (n !== 3 || rd !== e.rdata || er !== e.err) begin
      fails++;
      $display("FAIL load_full_word: cycle %0d rdata %h err %b, required cycle 3 rdata %h err %b",
               n, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_byte_enables();
    int n; logic [31:0] rd; logic er, st; exp_t e;
    access(1'b1, 32'h10, 4'b0001, 32'h000000AA, n, rd, er, st, e);
    access(1'b0, 32'h10, 4'h0, 32'h0, n, rd, er, st, e);
    tests++;
    if (rd !== e.rdata || er !== e.err) begin
      fails++;
      $display("FAIL byte_merge: rdata %h err %b, required %h %b", rd, er, e.rdata, e.err);
    end
    access(1'b1, 32'h10, 4'b0000, 32'h12345678, n, rd, er, st, e);
    tests++;
    if (n !== 3 || er !== e.err) begin
      fails++;
      $display("FAIL be_zero_ack: cycle %0d err %b, required cycle 3 err %b", n, er, e.err);
    end
    access(1'b0, 32'h10, 4'h0, 32'h0, n, rd, er, st, e);
    tests++;
    if (rd !== e.rdata) begin
      fails++;
      $display("FAIL be_zero_nowrite: rdata %h required %h", rd, e.rdata);
    end
  endtask

  task automatic test_latency3();
    logic exp_st, exp_ack;
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h10; be3 = 4'hF; wdata3 = 32'h0BADF00D;
    #1;
    tests++;
    if (stall3 !== 1'b1) begin
      fails++;
      $display("FAIL lat3_stall_request: stall %b required 1", stall3);
    end
    @(posedge clk);
    #1;
    req3 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      exp_st  = (n <= 3);
      exp_ack = (n == 4);
      tests++;
      if (stall3 !== exp_st || ack3 !== exp_ack || (ack3 === 1'b1 && err3 !== 1'b0)) begin
        fails++;
        $display("FAIL lat3_cycle%0d: stall/ack/err %b/%b/%b required %b/%b/0",
                 n, stall3, ack3, err3, exp_st, exp_ack);
      end
    end
  endtask

  task automatic test_errors();
    int n; logic [31:0] rd; logic er, st; exp_t e;
    access(1'b0, 32'h13, 4'h0, 32'h0, n, rd, er, st, e);
    tests++;
    if (n !== 3 || er !== e.err || rd !== e.rdata) begin
      fails++;
      $display("FAIL misaligned_load: cycle %0d err %b rdata %h, required 3 %b %h",
               n, er, rd, e.err, e.rdata);
    end
    access(1'b1, 32'h0, 4'hF, 32'h11111111, n, rd, er, st, e);
    access(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, n, rd, er, st, e);
    tests++;
    if (n !== 3 || er !== e.err || rd !== e.rdata) begin
      fails++;
      $display("FAIL range_store: cycle %0d err %b rdata %h, required 3 %b %h",
               n, er, rd, e.err, e.rdata);
    end
    access(1'b0, 32'h0, 4'h0, 32'h0, n, rd, er, st, e);
    tests++;
    if (rd !== e.rdata || er !== e.err) begin
      fails++;
      $display("FAIL range_store_suppressed: word0 %h err %b, required %h %b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_mid_access();
    int n; logic [31:0] rd; logic er, st; exp_t e;
    access(1'b1, 32'h40, 4'hF, 32'h12345678, n, rd, er, st, e);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ack, err, stall, rdata} !== 35'd0) begin
      fails++;
      $display("FAIL reset_mid_wait: ack/err/stall/rdata %b/%b/%b/%h required all zero",
               ack, err, stall, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    access(1'b0, 32'h40, 4'h0, 32'h0, n, rd, er, st, e);
    tests++;
    if (rd !== e.rdata || er !== e.err) begin
      fails++;
      $display("FAIL aborted_store_unwritten: rdata %h err %b, required %h %b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    int   pulses;
    exp_t e;
    model_push(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
    model_push(1'b0, 32'h20, 4'h0, 32'h0);
    pulses = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    we = 1'b0; wdata = $urandom;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        pulses++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra_ack: unexpected ack at cycle %0d", n);
        end else begin
          e = exp_q.pop_front();
          if ((n != 3 && n != 7) || rdata !== e.rdata || err !== e.err) begin
            fails++;
            $display("FAIL b2b_ack%0d: cycle %0d rdata %h err %b, required cycle %0d rdata %h err %b",
                     pulses, n, rdata, err, (pulses == 1) ? 3 : 7, e.rdata, e.err);
          end
        end
      end
      if (n == 4) begin
        tests++;
        if (ack !== 1'b0 || stall !== 1'b1) begin
          fails++;
          $display("FAIL b2b_idle_gap: ack/stall %b/%b required 0/1", ack, stall);
        end
      end
      if (n == 5) req = 1'b0;
    end
    tests++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL b2b_pulse_count: got %0d required 2", pulses);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_latency3();
    test_errors();
    test_reset_mid_access();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
